// File: rtl/cpu_pkg.sv
// Shared CPU definitions: run-control state encodings and fetch constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
  localparam int          PC_STEP            = 4;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write from the loader, combinational read for fetch.
module imem_ram #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage: PC, redirect, instruction RAM, IF/ID register and
// IDLE/RUN/HALT run control with a fetch counter.
module if_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int                    NB_PC           = 32,
  parameter int                    IMEM_ADDR_WIDTH = 10,
  parameter int                    NB_INSTR        = 32,
  parameter logic [NB_PC-1:0]      RESET_PC        = '0,
  parameter logic [NB_INSTR-1:0]   HALT_INSTR      = NB_INSTR'(DEFAULT_HALT_INSTR),
  parameter int                    NB_CNT          = 32
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_clear,
  input  logic                       i_stall,
  input  logic                       i_redirect,
  input  logic [NB_PC-1:0]           i_redirect_pc,
  input  logic                       i_load_wen,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_load_addr,
  input  logic [NB_INSTR-1:0]        i_load_data,
  output logic [NB_INSTR-1:0]        o_instr,
  output logic [NB_PC-1:0]           o_pc,
  output logic [NB_PC-1:0]           o_pc_plus4,
  output logic                       o_valid,
  output logic [1:0]                 o_state,
  output logic                       o_halted,
  output logic                       o_misalign,
  output logic [NB_CNT-1:0]          o_fetch_cnt
);

  localparam logic [NB_INSTR-1:0] NOP = NB_INSTR'(NOP_INSTR);
  localparam logic [NB_PC-1:0]    STEP = NB_PC'(PC_STEP);

  state_t                r_state;
  logic [NB_PC-1:0]      r_pc;
  logic [NB_INSTR-1:0]   r_instr;
  logic [NB_PC-1:0]      r_if_pc;
  logic [NB_PC-1:0]      r_if_pc_plus4;
  logic                  r_valid;
  logic                  r_misalign;
  logic [NB_CNT-1:0]     r_fetch_cnt;

  logic                       w_ram_wen;
  logic [IMEM_ADDR_WIDTH-1:0] w_ram_raddr;
  logic [NB_INSTR-1:0]        w_fetch;
  logic [NB_PC-1:0]           w_pc_plus4;

  // Loader is only allowed to touch the RAM while the core is not fetching.
  assign w_ram_wen   = i_load_wen && (r_state == ST_IDLE);
  assign w_ram_raddr = r_pc[IMEM_ADDR_WIDTH+1:2];
  assign w_pc_plus4  = r_pc + STEP;

  imem_ram #(
    .ADDR_W (IMEM_ADDR_WIDTH),
    .WORD_W (NB_INSTR)
  ) u_imem (
    .clk     (clk),
    .i_wen   (w_ram_wen),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_fetch)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_if_pc       <= RESET_PC;
      r_if_pc_plus4 <= RESET_PC + STEP;
      r_valid       <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_cnt   <= '0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_pc    <= RESET_PC;
          r_valid <= 1'b0;
          if (i_start) begin
            r_state     <= ST_RUN;
            r_fetch_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (i_redirect) begin
            r_pc       <= {i_redirect_pc[NB_PC-1:2], 2'b00};
            r_instr    <= NOP;
            r_valid    <= 1'b0;
            r_misalign <= |i_redirect_pc[1:0];
          end else if (i_stall) begin
            r_pc <= r_pc;
          end else if (w_fetch == HALT_INSTR) begin
            // Halt word is never issued; PC stays on it.
            r_instr <= NOP;
            r_valid <= 1'b0;
            r_state <= ST_HALT;
          end else begin
            r_instr       <= w_fetch;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_valid       <= 1'b1;
            r_pc          <= w_pc_plus4;
            r_fetch_cnt   <= r_fetch_cnt + NB_CNT'(1);
          end
        end
        ST_HALT: begin
          r_valid <= 1'b0;
          if (i_clear) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pc    <= RESET_PC;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_instr     = r_instr;
  assign o_pc        = r_if_pc;
  assign o_pc_plus4  = r_if_pc_plus4;
  assign o_valid     = r_valid;
  assign o_misalign  = r_misalign;
  assign o_fetch_cnt = r_fetch_cnt;
  assign o_state     = r_state;
  assign o_halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: load, run, halt, stall, redirect, wrap, reset.
module tb_if_stage_ctrl;

  localparam logic [31:0] I_A  = 32'h0010_0093;
  localparam logic [31:0] I_B  = 32'h0020_0113;
  localparam logic [31:0] I_C  = 32'h0030_0193;
  localparam logic [31:0] I_D  = 32'h0040_0213;
  localparam logic [31:0] I_E  = 32'h0050_0293;
  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_clear, i_stall, i_redirect, i_load_wen;
  logic [31:0] i_redirect_pc;
  logic [9:0]  i_load_addr;
  logic [31:0] i_load_data;
  logic [31:0] o_instr, o_pc, o_pc_plus4, o_fetch_cnt;
  logic        o_valid, o_halted, o_misalign;
  logic [1:0]  o_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage_ctrl dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_clear       (i_clear),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_load_wen    (i_load_wen),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_valid       (o_valid),
    .o_state       (o_state),
    .o_halted      (o_halted),
    .o_misalign    (o_misalign),
    .o_fetch_cnt   (o_fetch_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] addr, input logic [31:0] data);
    i_load_wen  = 1'b1;
    i_load_addr = addr;
    i_load_data = data;
    tick();
    i_load_wen  = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_clear = 1'b0; i_stall = 1'b0;
    i_redirect = 1'b0; i_redirect_pc = '0;
    i_load_wen = 1'b0; i_load_addr = '0; i_load_data = '0;
    tick(); tick();
    chk("rst_pc", o_pc, 0);
    chk("rst_pc4", o_pc_plus4, 4);
    chk("rst_instr", o_instr, NOPI);
    chk("rst_valid", o_valid, 0);
    chk("rst_state", o_state, 0);
    chk("rst_cnt", o_fetch_cnt, 0);
    chk("rst_mis", o_misalign, 0);
    i_rst = 1'b0;
    tick();

    load(10'd0, I_A); load(10'd1, I_B); load(10'd2, I_C); load(10'd3, HLT);
    load(10'd8, I_D); load(10'd9, NOPI); load(10'd16, I_E); load(10'd17, NOPI);

    // First run: A, B, C then halt
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("run_state", o_state, 1);
    chk("run_valid0", o_valid, 0);
    tick();
    chk("f0_pc", o_pc, 0);  chk("f0_instr", o_instr, I_A);
    chk("f0_valid", o_valid, 1); chk("f0_pc4", o_pc_plus4, 4); chk("f0_cnt", o_fetch_cnt, 1);
    tick();
    chk("f1_pc", o_pc, 4);  chk("f1_instr", o_instr, I_B); chk("f1_valid", o_valid, 1);
    tick();
    chk("f2_pc", o_pc, 8);  chk("f2_instr", o_instr, I_C); chk("f2_cnt", o_fetch_cnt, 3);
    tick();
    chk("halt_flag", o_halted, 1); chk("halt_state", o_state, 2);
    chk("halt_valid", o_valid, 0); chk("halt_cnt", o_fetch_cnt, 3);

    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("halt_ign_start", o_state, 2);
    load(10'd1, JUNK);
    i_clear = 1'b1; tick(); i_clear = 1'b0;
    chk("clr_state", o_state, 0); chk("clr_halted", o_halted, 0);

    // Second run: stall at PC=8 with a dropped load
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("run2_cnt0", o_fetch_cnt, 0);
    tick();
    chk("r2f0_pc", o_pc, 0); chk("r2f0_cnt", o_fetch_cnt, 1);
    tick();
    chk("r2f1_pc", o_pc, 4); chk("r2f1_instr", o_instr, I_B);
    i_stall = 1'b1;
    i_load_wen = 1'b1; i_load_addr = 10'd2; i_load_data = JUNK;
    tick();
    i_load_wen = 1'b0;
    chk("stall1_pc", o_pc, 4); chk("stall1_cnt", o_fetch_cnt, 2);
    tick();
    chk("stall2_pc", o_pc, 4); chk("stall2_instr", o_instr, I_B); chk("stall2_cnt", o_fetch_cnt, 2);
    i_stall = 1'b0;
    tick();
    chk("resume_pc", o_pc, 8); chk("resume_instr", o_instr, I_C);
    chk("resume_valid", o_valid, 1); chk("resume_cnt", o_fetch_cnt, 3);

    // Redirect while HALT word is being fetched
    i_redirect = 1'b1; i_redirect_pc = 32'h40; tick(); i_redirect = 1'b0;
    chk("rdh_state", o_state, 1); chk("rdh_valid", o_valid, 0);
    chk("rdh_instr", o_instr, NOPI); chk("rdh_cnt", o_fetch_cnt, 3);
    tick();
    chk("rdh_pc", o_pc, 32'h40); chk("rdh_instr2", o_instr, I_E); chk("rdh_cnt2", o_fetch_cnt, 4);

    // Misaligned redirect beats stall
    i_redirect = 1'b1; i_redirect_pc = 32'h22; i_stall = 1'b1; tick();
    i_redirect = 1'b0; i_stall = 1'b0;
    chk("mis_valid", o_valid, 0); chk("mis_pulse", o_misalign, 1); chk("mis_cnt", o_fetch_cnt, 4);
    tick();
    chk("mis_pc", o_pc, 32'h20); chk("mis_instr", o_instr, I_D);
    chk("mis_clear", o_misalign, 0); chk("mis_cnt2", o_fetch_cnt, 5);

    // Address wrap: 0x1000 maps to word 0
    i_redirect = 1'b1; i_redirect_pc = 32'h1000; tick(); i_redirect = 1'b0;
    chk("wrap_mis", o_misalign, 0);
    tick();
    chk("wrap_pc", o_pc, 32'h1000); chk("wrap_instr", o_instr, I_A);
    chk("wrap_pc4", o_pc_plus4, 32'h1004); chk("wrap_cnt", o_fetch_cnt, 6);

    // Asynchronous reset mid-run
    #2 i_rst = 1'b1;
    #1;
    chk("arst_pc", o_pc, 0); chk("arst_instr", o_instr, NOPI);
    chk("arst_valid", o_valid, 0); chk("arst_state", o_state, 0); chk("arst_cnt", o_fetch_cnt, 0);
    tick();
    i_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
